pc_unit: RTL

Parametrised program counter for the MIPS CPU fetch stage, generalising the plain increment-only counter. It adds taken-branch and register-jump redirection with MIPS branch-delay-slot semantics, fetch stall, a configurable reset vector, and halt detection on a jump to address 0. It drives the instruction-memory address and tells the rest of the core whether the CPU is still active.

---
 rtl/pc_unit_if.sv | 24 ++
 rtl/pc_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Fetch-stage PC bus: redirect/stall requests from the core, fetch address and status back.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump_reg;
    logic [WIDTH-1:0] Rd;
    logic [WIDTH-1:0] addr;
    logic             in_delay_slot;
    logic             active;
    logic             addr_error;

    modport master (
        output stall, branch_taken, branch_target, jump_reg, Rd,
        input  addr, in_delay_slot, active, addr_error
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump_reg, Rd,
        output addr, in_delay_slot, active, addr_error
    );
endinterface

// File: rtl/pc_unit.sv
// MIPS fetch program counter with delay-slot redirect, stall, and halt on a jump to 0.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky addr_error and halt.
//
// state | meaning
// SEQ   | sequential fetch; redirects are accepted here
// DELAY | delay slot is at addr; pending target loads on next advance
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'hBFC00000),
    parameter int               INCREMENT    = 4
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);
    typedef enum logic {SEQ, DELAY} state_t;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

    state_t           state_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] pending_q;
    logic             active_q;
    logic             redirect;
    logic [WIDTH-1:0] target;

    always_comb begin
        redirect = bus.jump_reg | bus.branch_taken;
        target   = bus.jump_reg ? bus.Rd : bus.branch_target;
    end

`ifdef PC_ALIGN_CHECK_EN
    logic addr_error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEQ;
            addr_q       <= RESET_VECTOR;
            pending_q    <= '0;
            active_q     <= 1'b1;
            addr_error_q <= 1'b0;
        end else if (!bus.stall && active_q) begin
            case (state_q)
                SEQ: begin
                    if (redirect) begin
                        // A bad target stops the CPU before the delay slot is fetched.
                        if (|target[1:0]) begin
                            addr_error_q <= 1'b1;
                            active_q     <= 1'b0;
                        end else begin
                            pending_q <= target;
                            addr_q    <= addr_q + STEP;
                            state_q   <= DELAY;
                        end
                    end else begin
                        addr_q <= addr_q + STEP;
                    end
                end
                DELAY: begin
                    addr_q  <= pending_q;
                    state_q <= SEQ;
                    if (pending_q == '0) active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_error = addr_error_q;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEQ;
            addr_q    <= RESET_VECTOR;
            pending_q <= '0;
            active_q  <= 1'b1;
        end else if (!bus.stall && active_q) begin
            case (state_q)
                SEQ: begin
                    addr_q <= addr_q + STEP;
                    if (redirect) begin
                        // Without the checker, low address bits are silently dropped.
                        pending_q <= target & ~WIDTH'(3);
                        state_q   <= DELAY;
                    end
                end
                DELAY: begin
                    addr_q  <= pending_q;
                    state_q <= SEQ;
                    if (pending_q == '0) active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_error = 1'b0;
`endif

    assign bus.addr          = addr_q;
    assign bus.in_delay_slot = (state_q == DELAY);
    assign bus.active        = active_q;
endmodule
